// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 constants, FSM state codes and phase type
package rc4_pkg;

    localparam int S_SIZE           = 256;
    localparam int KSA_CYCLES_PER_I = 6;
    localparam int DROP_COUNT       = 256;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE  = 4'd0;
    localparam state_t ST_INIT  = 4'd1;
    localparam state_t ST_RD_I  = 4'd2;
    localparam state_t ST_GET_I = 4'd3;
    localparam state_t ST_RD_J  = 4'd4;
    localparam state_t ST_GET_J = 4'd5;
    localparam state_t ST_WR_I  = 4'd6;
    localparam state_t ST_WR_J  = 4'd7;
    localparam state_t ST_READY = 4'd8;
    localparam state_t ST_RD_K  = 4'd9;
    localparam state_t ST_GET_K = 4'd10;
    localparam state_t ST_OUT   = 4'd11;

    // The swap loop RD_I..WR_J is shared; phase decides what follows WR_J.
    typedef enum logic [1:0] {
        PH_KSA  = 2'd0,
        PH_DROP = 2'd1,
        PH_PRGA = 2'd2
    } phase_t;

endpackage

// File: rtl/rc4_s_init.sv
// rtl/rc4_s_init.sv - S-box identity fill counter with single-cycle done pulse
module rc4_s_init
    import rc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    output logic [7:0] addr,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (en) begin
            count <= count + 8'd1;
        end
    end

    assign addr = count;
    assign done = en && (count == 8'(S_SIZE - 1));

endmodule

// File: rtl/rc4_encryption_core.sv
// rtl/rc4_encryption_core.sv - RC4 byte-stream encryptor on external S memory; RC4_DROP256_EN enables drop-256
module rc4_encryption_core
    import rc4_pkg::*;
#(
    parameter int KEY_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [8*KEY_LEN-1:0] secret_key,
    input  logic                 pt_valid,
    output logic                 pt_ready,
    input  logic [7:0]           pt_data,
    input  logic                 pt_last,
    output logic                 ct_valid,
    input  logic                 ct_ready,
    output logic [7:0]           ct_data,
    output logic                 ct_last,
    output logic                 busy,
    output logic                 key_ready,
    output logic [7:0]           s_address,
    output logic [7:0]           s_data,
    output logic                 s_wren,
    input  logic [7:0]           s_q
);

    state_t               state;
    phase_t               phase;
    logic [7:0]           i, j, si, sj;
    logic [2:0]           kidx;
    logic [8*KEY_LEN-1:0] key_reg;
    logic [7:0]           pt_reg, ct_reg;
    logic                 pt_last_reg, ct_last_reg;
    logic [7:0]           key_byte;
    logic [7:0]           init_addr;
    logic                 init_done;
`ifdef RC4_DROP256_EN
    logic [7:0]           drop_cnt;
`endif

    rc4_s_init u_s_init (
        .clk   (clk),
        .rst   (reset),
        .clear (state == ST_IDLE),
        .en    (state == ST_INIT),
        .addr  (init_addr),
        .done  (init_done)
    );

    always_comb begin
        key_byte = 8'h00;
        for (int n = 0; n < KEY_LEN; n++) begin
            if (kidx == 3'(n)) key_byte = key_reg[8*(KEY_LEN-1-n) +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            phase       <= PH_KSA;
            i           <= 8'd0;
            j           <= 8'd0;
            si          <= 8'd0;
            sj          <= 8'd0;
            kidx        <= 3'd0;
            key_reg     <= '0;
            pt_reg      <= 8'd0;
            pt_last_reg <= 1'b0;
            ct_reg      <= 8'd0;
            ct_last_reg <= 1'b0;
`ifdef RC4_DROP256_EN
            drop_cnt    <= 8'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    key_reg <= secret_key;
                    i       <= 8'd0;
                    j       <= 8'd0;
                    kidx    <= 3'd0;
                    phase   <= PH_KSA;
                    state   <= ST_INIT;
                end
                ST_INIT: if (init_done) state <= ST_RD_I;
                ST_RD_I: state <= ST_GET_I;
                ST_GET_I: begin
                    si <= s_q;
                    if (phase == PH_KSA) begin
                        j    <= j + s_q + key_byte;
                        kidx <= (kidx == 3'(KEY_LEN - 1)) ? 3'd0 : kidx + 3'd1;
                    end else begin
                        j <= j + s_q;
                    end
                    state <= ST_RD_J;
                end
                ST_RD_J: state <= ST_GET_J;
                ST_GET_J: begin
                    sj    <= s_q;
                    state <= ST_WR_I;
                end
                ST_WR_I: state <= ST_WR_J;
                ST_WR_J: begin
                    if (phase == PH_KSA) begin
                        if (i == 8'hFF) begin
                            j <= 8'd0;
`ifdef RC4_DROP256_EN
                            // Discard rounds pre-increment i, just like a real PRGA byte.
                            i        <= 8'd1;
                            drop_cnt <= 8'd0;
                            phase    <= PH_DROP;
                            state    <= ST_RD_I;
`else
                            i     <= 8'd0;
                            phase <= PH_PRGA;
                            state <= ST_READY;
`endif
                        end else begin
                            i     <= i + 8'd1;
                            state <= ST_RD_I;
                        end
`ifdef RC4_DROP256_EN
                    end else if (phase == PH_DROP) begin
                        if (drop_cnt == 8'(DROP_COUNT - 1)) begin
                            phase <= PH_PRGA;
                            state <= ST_READY;
                        end else begin
                            i        <= i + 8'd1;
                            drop_cnt <= drop_cnt + 8'd1;
                            state    <= ST_RD_I;
                        end
`endif
                    end else begin
                        state <= ST_RD_K;
                    end
                end
                ST_READY: if (pt_valid) begin
                    pt_reg      <= pt_data;
                    pt_last_reg <= pt_last;
                    i           <= i + 8'd1;
                    state       <= ST_RD_I;
                end
                ST_RD_K: state <= ST_GET_K;
                ST_GET_K: begin
                    ct_reg      <= pt_reg ^ s_q;
                    ct_last_reg <= pt_last_reg;
                    state       <= ST_OUT;
                end
                ST_OUT: if (ct_ready) state <= ct_last_reg ? ST_IDLE : ST_READY;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // S memory port: si+sj is read after both swap writes, so RD_K sees post-swap S.
    always_comb begin
        s_address = 8'd0;
        s_data    = 8'd0;
        s_wren    = 1'b0;
        case (state)
            ST_INIT: begin
                s_address = init_addr;
                s_data    = init_addr;
                s_wren    = 1'b1;
            end
            ST_RD_I: s_address = i;
            ST_RD_J: s_address = j;
            ST_WR_I: begin
                s_address = i;
                s_data    = sj;
                s_wren    = 1'b1;
            end
            ST_WR_J: begin
                s_address = j;
                s_data    = si;
                s_wren    = 1'b1;
            end
            ST_RD_K: s_address = si + sj;
            default: s_address = 8'd0;
        endcase
    end

    assign busy      = (state != ST_IDLE);
    assign key_ready = (state == ST_READY);
    assign pt_ready  = (state == ST_READY);
    assign ct_valid  = (state == ST_OUT);
    assign ct_data   = ct_reg;
    assign ct_last   = ct_last_reg;

endmodule
